// File: rtl/nn_frame_loader_if.sv
// Host-side stream bundle for the frame loader: a sample input stream and a
// result output stream, both valid/ready.
interface nn_frame_loader_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic                    s_valid;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_data;
  logic                    s_last;
  logic                    m_valid;
  logic                    m_ready;
  logic signed [WIDTH-1:0] m_data;

  // Host side: sends samples, receives results.
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );

  // Loader side: receives samples, sends results.
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/nn_frame_loader.sv
// Streaming front end for the one-layer network: assembles serial samples into
// a parallel frame, holds it while the network computes, then captures and
// returns the scalar result.
module nn_frame_loader #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned NFRAC          = 8,
  parameter int unsigned SYS_INPUT_SIZE = 10,
  parameter int unsigned NN_LATENCY     = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nn_frame_loader_if.slave        bus,
  output logic signed [WIDTH-1:0] frame_data [SYS_INPUT_SIZE],
  input  logic signed [WIDTH-1:0] nn_result,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int unsigned IdxW = (SYS_INPUT_SIZE > 1) ? $clog2(SYS_INPUT_SIZE) : 1;
  localparam int unsigned CntW = (NN_LATENCY > 1) ? $clog2(NN_LATENCY) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(SYS_INPUT_SIZE - 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(NN_LATENCY - 1);

  // Reject parameter sets the datapath cannot represent.
  if (SYS_INPUT_SIZE < 2) begin : g_bad_size
    $error("SYS_INPUT_SIZE must be at least 2");
  end
  if (NN_LATENCY < 1) begin : g_bad_latency
    $error("NN_LATENCY must be at least 1");
  end
  if (NFRAC > WIDTH) begin : g_bad_nfrac
    $error("NFRAC must not exceed WIDTH");
  end

  typedef enum logic [1:0] {StFill, StWait, StHold} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic signed [WIDTH-1:0] stage_q [SYS_INPUT_SIZE-1];
  logic signed [WIDTH-1:0] stage_d [SYS_INPUT_SIZE-1];
  logic signed [WIDTH-1:0] frame_q [SYS_INPUT_SIZE];
  logic signed [WIDTH-1:0] frame_d [SYS_INPUT_SIZE];
  logic signed [WIDTH-1:0] m_data_q, m_data_d;
  logic                    err_q, err_d;

  // State-decoded handshake and status outputs; no input reaches them.
  assign bus.s_ready = (state_q == StFill);
  assign bus.m_valid = (state_q == StHold);
  assign busy        = (state_q != StFill);
  assign bus.m_data  = m_data_q;
  assign frame_data  = frame_q;
  assign frame_err   = err_q;

  // Next-state logic for FSM, sample index, staging, frame and result.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    frame_d  = frame_q;
    m_data_d = m_data_q;
    err_d    = 1'b0;

    unique case (state_q)
      StFill: begin
        if (bus.s_valid) begin
          if (idx_q == LastIdx) begin
            // Final slot completes the frame even if s_last is missing.
            for (int i = 0; i < int'(SYS_INPUT_SIZE) - 1; i++) begin
              frame_d[i] = stage_q[i];
            end
            frame_d[SYS_INPUT_SIZE-1] = bus.s_data;
            idx_d   = '0;
            cnt_d   = CntLoad;
            err_d   = ~bus.s_last;
            state_d = StWait;
          end else begin
            for (int i = 0; i < int'(SYS_INPUT_SIZE) - 1; i++) begin
              if (idx_q == IdxW'(i)) begin
                stage_d[i] = bus.s_data;
              end
            end
            if (bus.s_last) begin
              // Early last: drop the partial frame and restart at slot 0.
              idx_d = '0;
              err_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          m_data_d = nn_result;
          state_d  = StHold;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (bus.m_ready) begin
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StFill;
      idx_q    <= '0;
      cnt_q    <= '0;
      m_data_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < int'(SYS_INPUT_SIZE) - 1; i++) begin
        stage_q[i] <= '0;
      end
      for (int i = 0; i < int'(SYS_INPUT_SIZE); i++) begin
        frame_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      m_data_q <= m_data_d;
      err_q    <= err_d;
      stage_q  <= stage_d;
      frame_q  <= frame_d;
    end
  end

endmodule

// File: tb/tb_nn_frame_loader.sv
// Scoreboard bench for nn_frame_loader: stimulus pushes expected frames and
// results, a negedge monitor pops and compares when the DUT presents them.
module tb_nn_frame_loader;

  localparam int W = 16;
  localparam int N = 10;
  localparam int L = 8;

  typedef logic [N-1:0][W-1:0] frame_p_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  nn_frame_loader_if #(.WIDTH(W)) bus ();
  logic signed [W-1:0] frame_data [N];
  logic signed [W-1:0] nn_result;
  logic                frame_err;
  logic                busy;

  nn_frame_loader #(
    .WIDTH         (W),
    .NFRAC         (8),
    .SYS_INPUT_SIZE(N),
    .NN_LATENCY    (L)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .frame_data(frame_data),
    .nn_result (nn_result),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input frame_p_t act, input frame_p_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    check(name, frame_p_t'(act), frame_p_t'(exp));
  endtask

  function automatic frame_p_t dut_frame();
    frame_p_t r;
    for (int i = 0; i < N; i++) r[i] = frame_data[i];
    return r;
  endfunction

  function automatic logic [W-1:0] sum_dut();
    logic [W-1:0] s = '0;
    for (int i = 0; i < N; i++) s = s + frame_data[i];
    return s;
  endfunction

  function automatic logic [W-1:0] sum_frame(input frame_p_t f);
    logic [W-1:0] s = '0;
    for (int i = 0; i < N; i++) s = s + f[i];
    return s;
  endfunction

  // Network stub: sum of the frame, visible L edges after frame_data changes.
  logic [W-1:0] pipe [L-1];
  logic         stub_const;
  always @(posedge clk) begin
    pipe[0] <= sum_dut();
    for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign nn_result = stub_const ? 16'sh0080 : signed'(pipe[L-2]);

  frame_p_t     exp_frames [$];
  logic [W-1:0] exp_results [$];

  // Monitor state
  logic     busy_prev = 1'b0;
  logic     mv_prev   = 1'b0;
  int       lat_cnt   = 0;
  int       err_seen  = 0;
  frame_p_t cur_frame = '0;

  // Pops expected frames/results and checks latency as the DUT presents them.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_prev = 1'b0;
      mv_prev   = 1'b0;
    end else begin
      if (frame_err) err_seen++;
      if (busy && busy_prev) lat_cnt++;
      if (busy && !busy_prev) begin
        lat_cnt = 0;
        if (exp_frames.size() == 0) begin
          check16("unexpected_frame", 16'd1, 16'd0);
        end else begin
          cur_frame = exp_frames.pop_front();
          check("frame_data", dut_frame(), cur_frame);
        end
      end
      if (bus.m_valid && !mv_prev) begin
        check16("result_latency", 16'(lat_cnt), 16'(L));
        check("frame_held", dut_frame(), cur_frame);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_results.size() == 0) begin
          check16("unexpected_result", 16'd1, 16'd0);
        end else begin
          check16("m_data", bus.m_data, exp_results.pop_front());
        end
      end
      busy_prev = busy;
      mv_prev   = bus.m_valid;
    end
  end

  // Reference model of frame assembly
  frame_p_t mdl_stage = '0;
  frame_p_t mdl_last  = '0;
  int       mdl_idx   = 0;
  int       exp_err   = 0;

  task automatic send(input logic [W-1:0] d, input bit last, input int gap);
    int t = 0;
    bus.s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!bus.s_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) begin
      check16("accept_timeout", 16'd1, 16'd0);
      bus.s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    mdl_stage[mdl_idx] = d;
    if (mdl_idx == N - 1) begin
      exp_frames.push_back(mdl_stage);
      exp_results.push_back(stub_const ? 16'h0080 : sum_frame(mdl_stage));
      mdl_last = mdl_stage;
      if (!last) exp_err++;
      mdl_idx = 0;
    end else if (last) begin
      exp_err++;
      mdl_idx = 0;
    end else begin
      mdl_idx++;
    end
  endtask

  task automatic wait_mvalid();
    int t = 0;
    while (!bus.m_valid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) check16("m_valid_timeout", 16'd1, 16'd0);
  endtask

  task automatic take_result();
    wait_mvalid();
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    check16("s_ready_after_take", 16'(bus.s_ready), 16'd1);
    check16("m_valid_after_take", 16'(bus.m_valid), 16'd0);
  endtask

  task automatic check_cleared(input string name);
    check(name, dut_frame(), '0);
    check16({name, "_flags"},
            16'({bus.s_ready, busy, bus.m_valid, frame_err}), 16'b1000);
    check16({name, "_m_data"}, bus.m_data, 16'd0);
  endtask

  task automatic flush_model();
    exp_frames.delete();
    exp_results.delete();
    mdl_idx  = 0;
    mdl_last = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] held;
    int           bad;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    stub_const  = 1'b1;
    reset_n     = 1'b0;
    #3;
    check_cleared("reset_values");
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame 1..10 with constant 0x0080 result
    for (int i = 1; i <= N; i++) send(W'(i), i == N, 0);
    check16("busy_after_frame", 16'({busy, bus.s_ready}), 16'b10);
    take_result();
    check16("no_err_basic", 16'(err_seen), 16'd0);

    // Backpressure: 20 cycles in HOLD, stray s_valid must be ignored
    stub_const = 1'b0;
    for (int i = 0; i < N; i++) send(W'(11 + 3 * i), i == N - 1, 0);
    wait_mvalid();
    held = bus.m_data;
    bad  = 0;
    for (int c = 0; c < 20; c++) begin
      bus.s_valid = c[0];
      bus.s_data  = 16'hDEAD;
      bus.s_last  = c[1];
      @(posedge clk);
      #1;
      if (!bus.m_valid || bus.m_data !== held || bus.s_ready) bad++;
    end
    bus.s_valid = 1'b0;
    check16("hold_stable", 16'(bad), 16'd0);
    take_result();

    // Early last after 4 samples
    for (int i = 0; i < 4; i++) send(W'(100 + i), i == 3, 0);
    check16("early_last_err", 16'(frame_err), 16'd1);
    check("early_last_frame", dut_frame(), mdl_last);
    @(posedge clk);
    #1;
    check16("early_last_err_pulse", 16'(frame_err), 16'd0);
    for (int i = 0; i < N; i++) send(W'(200 + i), i == N - 1, 0);
    take_result();

    // Missing last: frame still processed
    for (int i = 0; i < N; i++) send(W'(-5 * (i + 1)), 1'b0, 0);
    check16("missing_last_err", 16'(frame_err), 16'd1);
    take_result();
    check16("err_count", 16'(err_seen), 16'(exp_err));

    // Gapped input
    for (int i = 0; i < N; i++) send(W'(16'h1000 + 7 * i), i == N - 1, $urandom_range(0, 2));
    take_result();

    // Reset mid-FILL
    for (int i = 0; i < 5; i++) send(W'(300 + i), 1'b0, 0);
    #2 reset_n = 1'b0;
    #1;
    check_cleared("reset_mid_fill");
    flush_model();
    #4 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-WAIT: pending result is dropped
    for (int i = 0; i < N; i++) send(W'(400 + 2 * i), i == N - 1, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2 reset_n = 1'b0;
    #1;
    check_cleared("reset_mid_wait");
    flush_model();
    #4 reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < N; i++) send(W'(500 + i * i), i == N - 1, 0);
    take_result();
    repeat (2) @(posedge clk);
    check16("results_drained", 16'(exp_results.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
